// File: rtl/axilrealign.sv
// axilrealign: splits 32-bit little-endian fetch words into whole 16/32-bit
// instructions, each with its own PC and bus-error flag.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN      clock, synchronous active-low reset
//   i_cpu_reset, i_new_pc          flush requests (either one flushes)
//   i_valid/o_ready, i_word,
//   i_word_pc, i_illegal           upstream fetch word handshake
//   o_valid/i_ready, o_insn,
//   o_compressed, o_pc, o_illegal  downstream instruction handshake
module axilrealign #(
    parameter int AW             = 32,
    parameter bit OPT_COMPRESSED = 1'b1
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          i_cpu_reset,
    input  logic          i_new_pc,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [31:0]   i_word,
    input  logic [AW-1:0] i_word_pc,
    input  logic          i_illegal,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [31:0]   o_insn,
    output logic          o_compressed,
    output logic [AW-1:0] o_pc,
    output logic          o_illegal
);

    logic [47:0]   buf_q, buf_d;
    logic [2:0]    ill_q, ill_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          oill_q, oill_d;
    logic          comp_q, comp_d;
    logic [31:0]   insn_q, insn_d;
    logic [AW-1:0] opc_q, opc_d;

    logic          flush;
    logic          can_out;
    logic          front_c;
    logic          emit_c, emit_w, emit_e;
    logic [1:0]    used;
    logic [1:0]    rem;
    logic [47:0]   sh_buf;
    logic [2:0]    sh_ill;
    logic [31:0]   new_hw;
    logic [1:0]    new_ill;
    logic [1:0]    nh;

    always_comb begin
        flush   = i_cpu_reset | i_new_pc;
        can_out = (!valid_q || i_ready) && !oill_q;
        front_c = OPT_COMPRESSED && (buf_q[1:0] != 2'b11);

        emit_c = can_out && front_c && (cnt_q != 2'd0);
        emit_w = can_out && !front_c && (cnt_q >= 2'd2);
        // A faulted 32-bit front cannot wait for its second half.
        emit_e = can_out && !front_c && (cnt_q == 2'd1) && ill_q[0];

        used = 2'd0;
        if (emit_w) begin
            used = 2'd2;
        end else if (emit_c || emit_e) begin
            used = 2'd1;
        end
        rem     = cnt_q - used;
        o_ready = !oill_q && (rem <= 2'd1);

        sh_buf = buf_q >> {used, 4'd0};
        sh_ill = ill_q >> used;

        // Bit 1 of the word PC means only the upper halfword is valid.
        if (i_word_pc[1]) begin
            new_hw  = {16'h0000, i_word[31:16]};
            new_ill = {1'b0, i_illegal};
            nh      = 2'd1;
        end else begin
            new_hw  = i_word;
            new_ill = {2{i_illegal}};
            nh      = 2'd2;
        end

        buf_d = sh_buf;
        ill_d = sh_ill;
        cnt_d = rem;
        pc_d  = pc_q + {{(AW-3){1'b0}}, used, 1'b0};

        if (i_valid && o_ready) begin
            cnt_d = rem + nh;
            if (rem == 2'd0) begin
                buf_d = {16'h0000, new_hw};
                ill_d = {1'b0, new_ill};
                pc_d  = i_word_pc;
            end else begin
                buf_d = {new_hw, sh_buf[15:0]};
                ill_d = {new_ill, sh_ill[0]};
            end
        end

        valid_d = valid_q;
        oill_d  = oill_q;
        comp_d  = comp_q;
        insn_d  = insn_q;
        opc_d   = opc_q;

        if (emit_c || emit_w || emit_e) begin
            valid_d = 1'b1;
            comp_d  = emit_c;
            opc_d   = pc_q;
            if (emit_w) begin
                insn_d = buf_q[31:0];
                oill_d = |ill_q[1:0];
            end else begin
                insn_d = {16'h0000, buf_q[15:0]};
                oill_d = emit_e | ill_q[0];
            end
        end else if (i_ready && !oill_q) begin
            valid_d = 1'b0;
        end

        if (flush) begin
            cnt_d   = 2'd0;
            valid_d = 1'b0;
            oill_d  = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            buf_q   <= '0;
            ill_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            oill_q  <= 1'b0;
            comp_q  <= 1'b0;
            insn_q  <= '0;
            opc_q   <= '0;
        end else begin
            buf_q   <= buf_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            oill_q  <= oill_d;
            comp_q  <= comp_d;
            insn_q  <= insn_d;
            opc_q   <= opc_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_illegal    = oill_q;
    assign o_compressed = comp_q;
    assign o_insn       = insn_q;
    assign o_pc         = opc_q;

endmodule

// File: tb/tb_axilrealign.sv
// tb_axilrealign: directed + randomized bench for axilrealign, checked
// against a halfword-queue reference model.
module tb_axilrealign;

    typedef struct {
        logic [15:0] d;
        logic [31:0] pc;
        bit          ill;
    } hw_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        bit          c;
        bit          ill;
    } ins_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
        bit          ill;
    } wd_t;

    logic        clk;
    logic        S_AXI_ARESETN;
    logic        i_cpu_reset;
    logic        i_new_pc;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_word;
    logic [31:0] i_word_pc;
    logic        i_illegal;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_insn;
    logic        o_compressed;
    logic [31:0] o_pc;
    logic        o_illegal;

    axilrealign #(.AW(32), .OPT_COMPRESSED(1'b1)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .i_cpu_reset  (i_cpu_reset),
        .i_new_pc     (i_new_pc),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_word       (i_word),
        .i_word_pc    (i_word_pc),
        .i_illegal    (i_illegal),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_insn       (o_insn),
        .o_compressed (o_compressed),
        .o_pc         (o_pc),
        .o_illegal    (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    hw_t  hq[$];
    ins_t eq[$];
    wd_t  dq[$];
    bit   dead = 0;

    logic [31:0] cur_word;
    logic [31:0] cur_pc;
    bit          cur_ill;
    bit          have_word = 0;
    bit          rnd_mode = 0;

    bit          stuck = 0;
    int          stuck_cnt = 0;
    bit          hold_v = 0;
    bit          post_fl = 0;
    logic [31:0] h_insn;
    logic [31:0] h_pc;
    logic        h_comp;
    logic        h_ill;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instructions are cut from the halfword stream purely by the
    // encoding rules; a faulted halfword ends the stream until a flush.
    function automatic void parse();
        while (!dead && hq.size() > 0) begin
            hw_t  f;
            ins_t n;
            f = hq[0];
            if (f.d[1:0] != 2'b11) begin
                n = '{{16'h0, f.d}, f.pc, 1'b1, f.ill};
                void'(hq.pop_front());
            end else if (hq.size() >= 2) begin
                n = '{{hq[1].d, f.d}, f.pc, 1'b0, f.ill | hq[1].ill};
                void'(hq.pop_front());
                void'(hq.pop_front());
            end else if (f.ill) begin
                n = '{{16'h0, f.d}, f.pc, 1'b0, 1'b1};
                void'(hq.pop_front());
            end else begin
                break;
            end
            eq.push_back(n);
            if (n.ill) dead = 1;
        end
    endfunction

    function automatic void push_word(input logic [31:0] w,
                                      input logic [31:0] pc, input bit il);
        if (pc[1]) begin
            hq.push_back('{w[31:16], pc, il});
        end else begin
            hq.push_back('{w[15:0], pc, il});
            hq.push_back('{w[31:16], pc + 32'd2, il});
        end
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[0] = 1'b0;
        return h;
    endfunction

    function automatic void new_stream();
        cur_pc    = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : $urandom;
        cur_pc[0] = 1'b0;
        cur_word  = {rand_hw(), rand_hw()};
        cur_ill   = 0;
        have_word = 1;
    endfunction

    function automatic void next_word();
        wd_t d;
        if (dq.size() > 0) begin
            d         = dq.pop_front();
            cur_word  = d.w;
            cur_pc    = d.pc;
            cur_ill   = d.ill;
            have_word = 1;
        end else if (rnd_mode) begin
            cur_pc    = cur_pc + (cur_pc[1] ? 32'd2 : 32'd4);
            cur_word  = {rand_hw(), rand_hw()};
            cur_ill   = ($urandom_range(0, 39) == 0);
            have_word = 1;
        end else begin
            have_word = 0;
        end
    endfunction

    task automatic step(input bit ff);
        bit   fl;
        bit   sel;
        ins_t e;
        i_valid   = have_word && (!rnd_mode || $urandom_range(0, 3) != 0);
        i_word    = cur_word;
        i_word_pc = cur_pc;
        i_illegal = cur_ill;
        i_ready   = !rnd_mode || ($urandom_range(0, 3) != 0);
        fl  = ff || stuck_cnt >= 4 ||
              (rnd_mode && $urandom_range(0, 149) == 0);
        sel = ($urandom_range(0, 1) == 1);
        i_new_pc    = fl && sel;
        i_cpu_reset = fl && !sel;
        @(negedge clk);
        if (hold_v) begin
            check("hold_valid", o_valid, 1);
            check("hold_insn", o_insn, h_insn);
            check("hold_pc", o_pc, h_pc);
            check("hold_comp", o_compressed, h_comp);
            check("hold_ill", o_illegal, h_ill);
        end
        if (post_fl) begin
            check("flush_valid", o_valid, 0);
            check("flush_ill", o_illegal, 0);
        end
        if (stuck) begin
            check("stuck_ready", o_ready, 0);
            check("stuck_valid", o_valid, 1);
            check("stuck_ill", o_illegal, 1);
            stuck_cnt++;
        end else if (o_valid && i_ready) begin
            if (eq.size() == 0) begin
                check("spurious_valid", o_valid, 0);
            end else begin
                e = eq.pop_front();
                check("pc", o_pc, e.pc);
                check("illegal", o_illegal, e.ill);
                if (!e.ill) begin
                    check("insn", o_insn, e.insn);
                    check("compressed", o_compressed, e.c);
                end
                if (o_illegal) stuck = 1;
            end
        end
        hold_v  = o_valid && !i_ready && !fl;
        h_insn  = o_insn;
        h_pc    = o_pc;
        h_comp  = o_compressed;
        h_ill   = o_illegal;
        post_fl = fl;
        if (i_valid && o_ready) begin
            if (!fl) push_word(cur_word, cur_pc, cur_ill);
            next_word();
        end
        if (fl) begin
            hq.delete();
            eq.delete();
            dead      = 0;
            stuck     = 0;
            stuck_cnt = 0;
            if (rnd_mode) new_stream();
        end
        parse();
        @(posedge clk);
        #1;
    endtask

    initial begin
        S_AXI_ARESETN = 1'b0;
        i_cpu_reset   = 1'b0;
        i_new_pc      = 1'b0;
        i_valid       = 1'b0;
        i_word        = '0;
        i_word_pc     = '0;
        i_illegal     = 1'b0;
        i_ready       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_illegal", o_illegal, 0);
        check("rst_insn", o_insn, 0);
        check("rst_pc", o_pc, 0);
        check("rst_comp", o_compressed, 0);
        check("rst_ready", o_ready, 1);
        @(posedge clk);
        #1;
        S_AXI_ARESETN = 1'b1;

        i_valid   = 1'b1;
        i_word    = 32'h0010_0513;
        i_word_pc = 32'h100;
        i_ready   = 1'b1;
        @(negedge clk);
        check("idle_ready", o_ready, 1);
        @(posedge clk);
        #1;
        i_word    = 32'h0020_0593;
        i_word_pc = 32'h104;
        @(negedge clk);
        check("lat_n1_valid", o_valid, 0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("lat_n2_valid", o_valid, 1);
        check("lat_n2_insn", o_insn, 32'h0010_0513);
        check("lat_n2_pc", o_pc, 32'h100);
        check("lat_n2_comp", o_compressed, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("seq2_valid", o_valid, 1);
        check("seq2_insn", o_insn, 32'h0020_0593);
        check("seq2_pc", o_pc, 32'h104);
        @(posedge clk);
        #1;

        step(1);
        dq.push_back('{32'h0513_4505, 32'h100, 1'b0});
        dq.push_back('{32'h4501_0010, 32'h104, 1'b0});
        next_word();
        repeat (12) step(0);

        step(1);
        dq.push_back('{32'h4501_ABCD, 32'h302, 1'b0});
        next_word();
        repeat (8) step(0);

        step(1);
        dq.push_back('{32'h0513_4505, 32'h100, 1'b0});
        dq.push_back('{32'hDEAD_BEEF, 32'h104, 1'b1});
        next_word();
        repeat (14) step(0);

        step(1);
        dq.push_back('{32'h4501_4505, 32'h200, 1'b0});
        dq.push_back('{32'h4501_4505, 32'h204, 1'b0});
        next_word();
        repeat (10) step(0);

        rnd_mode = 1;
        new_stream();
        repeat (4000) step(0);
        rnd_mode = 0;
        repeat (40) step(0);
        check("drain_empty", eq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
